// File: rtl/ll_node_alloc_arb_if.sv
// rtl/ll_node_alloc_arb_if.sv - allocation/free handshake bundle between list clients and the node allocator
interface ll_node_alloc_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 16,
  parameter int PTR_W   = $clog2(DEPTH)
);
  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  logic [PTR_W-1:0]   gnt_ptr;
  logic               free_vld;
  logic [PTR_W-1:0]   free_ptr;
  logic               ready;
  logic [PTR_W:0]     free_cnt;
  logic               empty;
  logic               err_dbl;

  modport master (
    output req, free_vld, free_ptr,
    input  gnt, gnt_ptr, ready, free_cnt, empty, err_dbl
  );

  modport slave (
    input  req, free_vld, free_ptr,
    output gnt, gnt_ptr, ready, free_cnt, empty, err_dbl
  );
endinterface

// File: rtl/ll_node_alloc_arb.sv
// rtl/ll_node_alloc_arb.sv - round-robin node allocator over a linked free list; optional LL_ALLOC_DBL_FREE_CHECK_EN
module ll_node_alloc_arb #(
  parameter int NUM_REQ = 4,
  parameter int DEPTH   = 16,
  parameter int PTR_W   = $clog2(DEPTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  ll_node_alloc_arb_if.slave   bus
);
  localparam int RR_W  = $clog2(NUM_REQ);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  typedef enum logic {S_INIT, S_RUN} state_t;

  state_t             state;
  logic [PTR_W-1:0]   init_idx;
  logic [PTR_W-1:0]   head;
  logic [PTR_W-1:0]   tail;
  logic [PTR_W-1:0]   nxt [DEPTH];
  logic [CNT_W-1:0]   cnt;
  logic [RR_W-1:0]    rr_ptr;
  logic               ready_q;

  logic [NUM_REQ-1:0] gnt_c;
  logic [RR_W-1:0]    win;
  logic               do_gnt;
  logic               do_free;
  logic               free_ok;
  int                 idx;

  // First requester at or after rr_ptr wins; nothing is granted from an empty pool.
  always_comb begin
    gnt_c  = '0;
    win    = '0;
    do_gnt = 1'b0;
    idx    = 0;
    if (ready_q && cnt != '0) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        idx = (int'(rr_ptr) + i) % NUM_REQ;
        if (!do_gnt && bus.req[idx]) begin
          do_gnt     = 1'b1;
          win        = RR_W'(idx);
          gnt_c[idx] = 1'b1;
        end
      end
    end
  end

`ifdef LL_ALLOC_DBL_FREE_CHECK_EN
  logic [DEPTH-1:0] alloc_map;
  logic             err_q;

  assign free_ok = alloc_map[bus.free_ptr] && (cnt != FULL);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alloc_map <= '0;
      err_q     <= 1'b0;
    end else begin
      err_q <= ready_q && bus.free_vld && !free_ok;
      if (do_gnt)
        alloc_map[head] <= 1'b1;
      if (do_free)
        alloc_map[bus.free_ptr] <= 1'b0;
    end
  end

  assign bus.err_dbl = err_q;
`else
  assign free_ok     = 1'b1;
  assign bus.err_dbl = 1'b0;
`endif

  assign do_free = ready_q && bus.free_vld && free_ok;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_INIT;
      init_idx <= '0;
      head     <= '0;
      tail     <= PTR_W'(DEPTH - 1);
      cnt      <= '0;
      rr_ptr   <= '0;
      ready_q  <= 1'b0;
    end else begin
      case (state)
        S_INIT: begin
          init_idx <= init_idx + 1'b1;
          if (init_idx == PTR_W'(DEPTH - 1)) begin
            state   <= S_RUN;
            ready_q <= 1'b1;
            cnt     <= FULL;
          end
        end
        S_RUN: begin
          if (do_gnt)
            rr_ptr <= (win == RR_W'(NUM_REQ - 1)) ? '0 : win + 1'b1;
          if (do_free)
            tail <= bus.free_ptr;
          // With one node left, a concurrent free becomes the new head directly.
          if (do_gnt && do_free)
            head <= (cnt == ONE) ? bus.free_ptr : nxt[head];
          else if (do_gnt)
            head <= nxt[head];
          else if (do_free && cnt == '0)
            head <= bus.free_ptr;
          if (do_gnt && !do_free)
            cnt <= cnt - 1'b1;
          else if (do_free && !do_gnt && cnt != FULL)
            cnt <= cnt + 1'b1;
        end
      endcase
    end
  end

  // Link storage has no reset; INIT rewrites every entry before use.
  always_ff @(posedge clk) begin
    if (state == S_INIT)
      nxt[init_idx] <= init_idx + 1'b1;
    else if (do_free)
      nxt[tail] <= bus.free_ptr;
  end

  assign bus.gnt      = gnt_c;
  assign bus.gnt_ptr  = head;
  assign bus.ready    = ready_q;
  assign bus.free_cnt = cnt;
  assign bus.empty    = (cnt == '0);
endmodule

// File: tb/tb_ll_node_alloc_arb.sv
// tb/tb_ll_node_alloc_arb.sv - self-checking bench: vector table, corner sequences, randomized queue model
module tb_ll_node_alloc_arb;
  localparam int N  = 4;
  localparam int D  = 16;
  localparam int PW = 4;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ll_node_alloc_arb_if #(.NUM_REQ(N), .DEPTH(D)) bus ();
  ll_node_alloc_arb #(.NUM_REQ(N), .DEPTH(D)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [N-1:0]  req;
    logic          fv;
    logic [PW-1:0] fp;
    logic [N-1:0]  gnt;
    logic [PW-1:0] ptr;
    logic [PW:0]   cnt;
  } vec_t;
  vec_t tbl [9];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [N-1:0] r, input logic fv, input logic [PW-1:0] fp);
    bus.req      = r;
    bus.free_vld = fv;
    bus.free_ptr = fp;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    drive('0, 1'b0, '0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    for (int i = 0; i < D; i++) begin
      @(negedge clk);
      chk("init_ready_low", bus.ready, 0);
    end
    @(negedge clk);
    chk("init_ready_high", bus.ready, 1);
    chk("init_free_cnt", bus.free_cnt, D);
    chk("init_empty", bus.empty, 0);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  int            fq [$];
  int            alloc [$];
  int            rr;
  int            w;
  int            j;
  int            k;
  logic [N-1:0]  mreq;
  logic [N-1:0]  egnt;
  logic          fv;
  logic [PW-1:0] fp;

  initial begin
    tbl[0] = '{4'b1111, 1'b0, 4'd0, 4'b0001, 4'd0, 5'd16};
    tbl[1] = '{4'b1111, 1'b0, 4'd0, 4'b0010, 4'd1, 5'd15};
    tbl[2] = '{4'b1111, 1'b0, 4'd0, 4'b0100, 4'd2, 5'd14};
    tbl[3] = '{4'b1111, 1'b0, 4'd0, 4'b1000, 4'd3, 5'd13};
    tbl[4] = '{4'b0000, 1'b1, 4'd2, 4'b0000, 4'd0, 5'd12};
    tbl[5] = '{4'b0101, 1'b0, 4'd0, 4'b0001, 4'd4, 5'd13};
    tbl[6] = '{4'b0101, 1'b0, 4'd0, 4'b0100, 4'd5, 5'd12};
    tbl[7] = '{4'b0001, 1'b1, 4'd0, 4'b0001, 4'd6, 5'd11};
    tbl[8] = '{4'b0000, 1'b0, 4'd0, 4'b0000, 4'd0, 5'd11};

    do_reset();
    for (int i = 0; i < 9; i++) begin
      drive(tbl[i].req, tbl[i].fv, tbl[i].fp);
      @(negedge clk);
      chk($sformatf("tbl%0d_gnt", i), bus.gnt, tbl[i].gnt);
      if (tbl[i].gnt != '0)
        chk($sformatf("tbl%0d_ptr", i), bus.gnt_ptr, tbl[i].ptr);
      chk($sformatf("tbl%0d_cnt", i), bus.free_cnt, tbl[i].cnt);
      tick();
    end

    // Drain the pool, hold a request on empty, then refill through single frees.
    do_reset();
    for (int i = 0; i < D; i++) begin
      drive(4'b0001, 1'b0, '0);
      @(negedge clk);
      chk("drain_gnt", bus.gnt, 4'b0001);
      chk("drain_ptr", bus.gnt_ptr, i);
      tick();
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("empty_no_gnt", bus.gnt, 0);
      chk("empty_cnt", bus.free_cnt, 0);
      chk("empty_flag", bus.empty, 1);
      tick();
    end
    drive(4'b0001, 1'b1, 4'd5);
    @(negedge clk);
    chk("no_bypass", bus.gnt, 0);
    tick();
    drive(4'b0001, 1'b0, '0);
    @(negedge clk);
    chk("refill_gnt", bus.gnt, 4'b0001);
    chk("refill_ptr", bus.gnt_ptr, 5);
    chk("refill_cnt", bus.free_cnt, 1);
    tick();
    drive('0, 1'b1, 4'd9);
    @(negedge clk);
    chk("pre_free9_cnt", bus.free_cnt, 0);
    tick();
    drive(4'b0100, 1'b1, 4'd3);
    @(negedge clk);
    chk("same_cyc_gnt", bus.gnt, 4'b0100);
    chk("same_cyc_ptr", bus.gnt_ptr, 9);
    chk("same_cyc_cnt_before", bus.free_cnt, 1);
    tick();
    drive(4'b0100, 1'b0, '0);
    @(negedge clk);
    chk("same_cyc_cnt_after", bus.free_cnt, 1);
    chk("same_cyc_next_gnt", bus.gnt, 4'b0100);
    chk("same_cyc_next_ptr", bus.gnt_ptr, 3);
    tick();
    drive('0, 1'b0, '0);
    @(negedge clk);
    chk("final_empty", bus.empty, 1);
    tick();

`ifdef LL_ALLOC_DBL_FREE_CHECK_EN
    do_reset();
    drive(4'b0001, 1'b0, '0);
    @(negedge clk);
    chk("dbl_alloc_ptr", bus.gnt_ptr, 0);
    tick();
    drive('0, 1'b1, 4'd0);
    @(negedge clk);
    chk("dbl_first_err", bus.err_dbl, 0);
    tick();
    drive('0, 1'b1, 4'd0);
    @(negedge clk);
    chk("dbl_second_cnt", bus.free_cnt, D);
    tick();
    drive('0, 1'b0, '0);
    @(negedge clk);
    chk("dbl_err_pulse", bus.err_dbl, 1);
    chk("dbl_cnt_kept", bus.free_cnt, D);
    tick();
    @(negedge clk);
    chk("dbl_err_clear", bus.err_dbl, 0);
    tick();
`endif

    // Reset while a grant is showing must kill it without waiting for a clock.
    do_reset();
    drive(4'b0010, 1'b0, '0);
    @(negedge clk);
    chk("rst_pre_gnt", bus.gnt, 4'b0010);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_gnt_drop", bus.gnt, 0);
    chk("rst_ready_drop", bus.ready, 0);
    do_reset();

    // Randomized traffic against a free-queue model.
    fq.delete();
    alloc.delete();
    for (int i = 0; i < D; i++) fq.push_back(i);
    rr   = 0;
    mreq = '0;
    for (int c = 0; c < 2000; c++) begin
      for (int r = 0; r < N; r++)
        if (!mreq[r] && $urandom_range(0, 2) == 0) mreq[r] = 1'b1;
      fv = 1'b0;
      fp = '0;
      if (alloc.size() > 0 && $urandom_range(0, 1) == 0) begin
        k  = $urandom_range(0, alloc.size() - 1);
        fp = PW'(alloc[k]);
        alloc.delete(k);
        fv = 1'b1;
      end
      drive(mreq, fv, fp);
      egnt = '0;
      w    = -1;
      if (fq.size() > 0)
        for (int i = 0; i < N; i++) begin
          j = (rr + i) % N;
          if (w < 0 && mreq[j]) w = j;
        end
      if (w >= 0) egnt[w] = 1'b1;
      @(negedge clk);
      chk("rnd_gnt", bus.gnt, egnt);
      if (w >= 0) chk("rnd_ptr", bus.gnt_ptr, fq[0]);
      chk("rnd_cnt", bus.free_cnt, fq.size());
      chk("rnd_empty", bus.empty, fq.size() == 0);
      chk("rnd_err", bus.err_dbl, 0);
      if (w >= 0) begin
        alloc.push_back(fq.pop_front());
        mreq[w] = 1'b0;
        rr      = (w + 1) % N;
      end
      if (fv) fq.push_back(int'(fp));
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
